// File: rtl/rename_regfile_mp.sv
// Architectural register file with rename-tag status for the Tomasulo core.
// Provides NRD combinational read ports with same-cycle CDB bypass, NCDB result
// buses, one dispatch (tag allocation) port and NCKPT tag-table checkpoints
// for branch recovery. Register 0 is hardwired to zero and never busy.
module rename_regfile_mp #(
  parameter int NREG  = 32,
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int NRD   = 2,
  parameter int NCDB  = 2,
  parameter int NCKPT = 4,
  parameter int AW    = $clog2(NREG),
  parameter int CW    = $clog2(NCKPT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCDB-1:0]       cdb_valid,
  input  logic [NCDB*AW-1:0]    cdb_name,
  input  logic [NCDB*XLEN-1:0]  cdb_data,
  input  logic [NCDB*TAG_W-1:0] cdb_tag,
  input  logic [NRD*AW-1:0]     rd_name,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  output logic [NRD*TAG_W-1:0]  rd_tag,
  input  logic                  disp_en,
  input  logic [AW-1:0]         disp_name,
  input  logic [TAG_W-1:0]      disp_tag,
  input  logic                  ckpt_save,
  input  logic [CW-1:0]         ckpt_id,
  input  logic                  ckpt_restore,
  input  logic [CW-1:0]         restore_id
);

  // Live architectural state
  logic [XLEN-1:0]  data_r      [NREG];
  logic [NREG-1:0]  busy_r;
  logic [TAG_W-1:0] tag_r       [NREG];
  // Checkpointed tag table
  logic [NREG-1:0]  ckpt_busy_r [NCKPT];
  logic [TAG_W-1:0] ckpt_tag_r  [NCKPT][NREG];

  // Next-state values
  logic [XLEN-1:0]  data_nx_s      [NREG];
  logic [NREG-1:0]  busy_nx_s;
  logic [TAG_W-1:0] tag_nx_s       [NREG];
  logic [NREG-1:0]  ckpt_busy_nx_s [NCKPT];
  logic [TAG_W-1:0] ckpt_tag_nx_s  [NCKPT][NREG];

  // Per-register CDB tag matches: against the live tag and against each snapshot tag
  logic [NREG-1:0]  live_clr_s;
  logic [NREG-1:0]  trk_clr_s [NCKPT];

  // Tag comparison of every valid bus against the live and checkpointed tag of its target register
  always_comb begin
    live_clr_s = '0;
    for (int k = 0; k < NCKPT; k++) begin
      trk_clr_s[k] = '0;
    end
    for (int b = 0; b < NCDB; b++) begin
      for (int r = 1; r < NREG; r++) begin
        live_clr_s[r] = live_clr_s[r] |
                        (cdb_valid[b] & (cdb_name[b*AW +: AW] == AW'(r)) &
                         (cdb_tag[b*TAG_W +: TAG_W] == tag_r[r]));
        for (int k = 0; k < NCKPT; k++) begin
          trk_clr_s[k][r] = trk_clr_s[k][r] |
                            (cdb_valid[b] & (cdb_name[b*AW +: AW] == AW'(r)) &
                             (cdb_tag[b*TAG_W +: TAG_W] == ckpt_tag_r[k][r]));
        end
      end
    end
  end

  // Next-state computation: CDB writeback, dispatch, restore and checkpoint save/tracking
  always_comb begin
    data_nx_s      = data_r;
    busy_nx_s      = busy_r;
    tag_nx_s       = tag_r;
    ckpt_busy_nx_s = ckpt_busy_r;
    ckpt_tag_nx_s  = ckpt_tag_r;

    // Data: ascending bus order so the highest-index bus wins on a name collision
    for (int b = 0; b < NCDB; b++) begin
      if (cdb_valid[b] && (cdb_name[b*AW +: AW] != '0)) begin
        data_nx_s[cdb_name[b*AW +: AW]] = cdb_data[b*XLEN +: XLEN];
      end else begin
        data_nx_s[0] = '0;
      end
    end
    data_nx_s[0] = '0;

    // Busy/tag: restore beats dispatch, dispatch beats a same-cycle wakeup
    for (int r = 1; r < NREG; r++) begin
      if (ckpt_restore) begin
        busy_nx_s[r] = ckpt_busy_r[restore_id][r] & ~trk_clr_s[restore_id][r];
        tag_nx_s[r]  = ckpt_tag_r[restore_id][r];
      end else if (disp_en && (disp_name == AW'(r))) begin
        busy_nx_s[r] = 1'b1;
        tag_nx_s[r]  = disp_tag;
      end else if (busy_r[r] && live_clr_s[r]) begin
        busy_nx_s[r] = 1'b0;
        tag_nx_s[r]  = tag_r[r];
      end else begin
        busy_nx_s[r] = busy_r[r];
        tag_nx_s[r]  = tag_r[r];
      end
    end
    busy_nx_s[0] = 1'b0;
    tag_nx_s[0]  = '0;

    // Checkpoints: a save captures the post-update table; other slots track wakeups
    for (int k = 0; k < NCKPT; k++) begin
      for (int r = 1; r < NREG; r++) begin
        if (ckpt_save && !ckpt_restore && (ckpt_id == CW'(k))) begin
          ckpt_busy_nx_s[k][r] = busy_nx_s[r];
          ckpt_tag_nx_s[k][r]  = tag_nx_s[r];
        end else if (trk_clr_s[k][r]) begin
          ckpt_busy_nx_s[k][r] = 1'b0;
        end else begin
          ckpt_busy_nx_s[k][r] = ckpt_busy_r[k][r];
        end
      end
      ckpt_busy_nx_s[k][0] = 1'b0;
      ckpt_tag_nx_s[k][0]  = '0;
    end
  end

  // State registers with synchronous reset to the all-free, all-zero table
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= '0;
      for (int r = 0; r < NREG; r++) begin
        data_r[r] <= '0;
        tag_r[r]  <= '0;
      end
      for (int k = 0; k < NCKPT; k++) begin
        ckpt_busy_r[k] <= '0;
        for (int r = 0; r < NREG; r++) begin
          ckpt_tag_r[k][r] <= '0;
        end
      end
    end else begin
      data_r      <= data_nx_s;
      busy_r      <= busy_nx_s;
      tag_r       <= tag_nx_s;
      ckpt_busy_r <= ckpt_busy_nx_s;
      ckpt_tag_r  <= ckpt_tag_nx_s;
    end
  end

  // Read ports with CDB bypass; dispatch in the same cycle is deliberately not visible
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rd_tag  = '0;
    for (int p = 0; p < NRD; p++) begin
      if (rst) begin
        rd_busy[p] = 1'b0;
      end else if (rd_name[p*AW +: AW] == '0) begin
        rd_busy[p] = 1'b0;
      end else begin
        rd_data[p*XLEN +: XLEN] = data_r[rd_name[p*AW +: AW]];
        rd_busy[p]              = busy_r[rd_name[p*AW +: AW]];
        rd_tag[p*TAG_W +: TAG_W] = tag_r[rd_name[p*AW +: AW]];
        for (int b = 0; b < NCDB; b++) begin
          if (cdb_valid[b] && (cdb_name[b*AW +: AW] == rd_name[p*AW +: AW])) begin
            rd_data[p*XLEN +: XLEN] = cdb_data[b*XLEN +: XLEN];
            if (cdb_tag[b*TAG_W +: TAG_W] == tag_r[rd_name[p*AW +: AW]]) begin
              rd_busy[p] = 1'b0;
            end else begin
              rd_busy[p] = rd_busy[p];
            end
          end else begin
            rd_busy[p] = rd_busy[p];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rename_regfile_mp.sv
// Directed self-checking bench for rename_regfile_mp.
module tb_rename_regfile_mp;
  localparam int NREG = 32, XLEN = 32, TAG_W = 4, NRD = 2, NCDB = 2, NCKPT = 4;
  localparam int AW = 5, CW = 2;

  logic                  clk;
  logic                  rst;
  logic [NCDB-1:0]       cdb_valid;
  logic [NCDB*AW-1:0]    cdb_name;
  logic [NCDB*XLEN-1:0]  cdb_data;
  logic [NCDB*TAG_W-1:0] cdb_tag;
  logic [NRD*AW-1:0]     rd_name;
  logic [NRD*XLEN-1:0]   rd_data;
  logic [NRD-1:0]        rd_busy;
  logic [NRD*TAG_W-1:0]  rd_tag;
  logic                  disp_en;
  logic [AW-1:0]         disp_name;
  logic [TAG_W-1:0]      disp_tag;
  logic                  ckpt_save;
  logic [CW-1:0]         ckpt_id;
  logic                  ckpt_restore;
  logic [CW-1:0]         restore_id;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  rename_regfile_mp #(
    .NREG(NREG), .XLEN(XLEN), .TAG_W(TAG_W), .NRD(NRD), .NCDB(NCDB), .NCKPT(NCKPT)
  ) dut (
    .clk(clk), .rst(rst),
    .cdb_valid(cdb_valid), .cdb_name(cdb_name), .cdb_data(cdb_data), .cdb_tag(cdb_tag),
    .rd_name(rd_name), .rd_data(rd_data), .rd_busy(rd_busy), .rd_tag(rd_tag),
    .disp_en(disp_en), .disp_name(disp_name), .disp_tag(disp_tag),
    .ckpt_save(ckpt_save), .ckpt_id(ckpt_id),
    .ckpt_restore(ckpt_restore), .restore_id(restore_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cdb_valid = '0; cdb_name = '0; cdb_data = '0; cdb_tag = '0;
    disp_en = 1'b0; disp_name = '0; disp_tag = '0;
    ckpt_save = 1'b0; ckpt_id = '0; ckpt_restore = 1'b0; restore_id = '0;
  endtask

  task automatic cdb(input int b, input logic [AW-1:0] nm, input logic [TAG_W-1:0] t,
                     input logic [XLEN-1:0] d);
    cdb_valid[b]               = 1'b1;
    cdb_name[b*AW +: AW]       = nm;
    cdb_tag[b*TAG_W +: TAG_W]  = t;
    cdb_data[b*XLEN +: XLEN]   = d;
  endtask

  task automatic disp(input logic [AW-1:0] nm, input logic [TAG_W-1:0] t);
    disp_en = 1'b1; disp_name = nm; disp_tag = t;
  endtask

  task automatic rd(input logic [AW-1:0] n0, input logic [AW-1:0] n1);
    rd_name = {n1, n0};
  endtask

  task automatic test_reset();
    idle(); rd(5'd5, 5'd0); cdb(0, 5'd5, 4'd0, 32'h77); tick();
    idle(); #1;
    chk_cnt++; if (rd_data[31:0] !== 32'h77) $display("FAIL r5_written: got %h want %h", rd_data[31:0], 32'h77); else pass_cnt++;
    rst = 1'b1; cdb(0, 5'd5, 4'd0, 32'h99); disp(5'd5, 4'd3); #1;
    chk_cnt++; if (rd_data[31:0] !== 32'h0) $display("FAIL rd_data_in_rst: got %h want %h", rd_data[31:0], 32'h0); else pass_cnt++;
    chk_cnt++; if (rd_busy[0] !== 1'b0) $display("FAIL rd_busy_in_rst: got %b want %b", rd_busy[0], 1'b0); else pass_cnt++;
    tick(); rst = 1'b0; idle(); #1;
    chk_cnt++; if (rd_data[31:0] !== 32'h0) $display("FAIL r5_after_rst: got %h want %h", rd_data[31:0], 32'h0); else pass_cnt++;
    chk_cnt++; if (rd_busy[0] !== 1'b0) $display("FAIL r5_busy_after_rst: got %b want %b", rd_busy[0], 1'b0); else pass_cnt++;
    rd(5'd0, 5'd0); cdb(0, 5'd0, 4'd0, 32'h55); disp(5'd0, 4'd1); #1;
    chk_cnt++; if (rd_data !== 64'h0) $display("FAIL r0_bypass: got %h want %h", rd_data, 64'h0); else pass_cnt++;
    tick(); idle(); #1;
    chk_cnt++; if (rd_data[31:0] !== 32'h0) $display("FAIL r0_stored: got %h want %h", rd_data[31:0], 32'h0); else pass_cnt++;
    chk_cnt++; if (rd_busy !== 2'b00) $display("FAIL r0_busy: got %b want %b", rd_busy, 2'b00); else pass_cnt++;
  endtask

  task automatic test_cdb_wakeup();
    idle(); rd(5'd3, 5'd3); disp(5'd3, 4'd7); tick();
    idle(); #1;
    chk_cnt++; if (rd_busy[0] !== 1'b1) $display("FAIL wake_busy_set: got %b want %b", rd_busy[0], 1'b1); else pass_cnt++;
    chk_cnt++; if (rd_tag[3:0] !== 4'd7) $display("FAIL wake_tag_set: got %0d want %0d", rd_tag[3:0], 7); else pass_cnt++;
    cdb(0, 5'd3, 4'd7, 32'hDEAD); #1;
    chk_cnt++; if (rd_data[63:32] !== 32'hDEAD) $display("FAIL wake_bypass_data: got %h want %h", rd_data[63:32], 32'hDEAD); else pass_cnt++;
    chk_cnt++; if (rd_busy !== 2'b00) $display("FAIL wake_bypass_busy: got %b want %b", rd_busy, 2'b00); else pass_cnt++;
    tick(); idle(); #1;
    chk_cnt++; if (rd_data[31:0] !== 32'hDEAD) $display("FAIL wake_stored_data: got %h want %h", rd_data[31:0], 32'hDEAD); else pass_cnt++;
    chk_cnt++; if (rd_busy[0] !== 1'b0) $display("FAIL wake_stored_busy: got %b want %b", rd_busy[0], 1'b0); else pass_cnt++;
  endtask

  task automatic test_stale_tag();
    idle(); rd(5'd3, 5'd3); disp(5'd3, 4'd7); tick();
    idle(); disp(5'd3, 4'd9); tick();
    idle(); cdb(0, 5'd3, 4'd7, 32'h11); #1;
    chk_cnt++; if (rd_data[31:0] !== 32'h11) $display("FAIL stale_bypass_data: got %h want %h", rd_data[31:0], 32'h11); else pass_cnt++;
    chk_cnt++; if (rd_busy[0] !== 1'b1) $display("FAIL stale_bypass_busy: got %b want %b", rd_busy[0], 1'b1); else pass_cnt++;
    tick(); idle(); #1;
    chk_cnt++; if (rd_data[31:0] !== 32'h11) $display("FAIL stale_data: got %h want %h", rd_data[31:0], 32'h11); else pass_cnt++;
    chk_cnt++; if (rd_busy[0] !== 1'b1) $display("FAIL stale_busy: got %b want %b", rd_busy[0], 1'b1); else pass_cnt++;
    chk_cnt++; if (rd_tag[3:0] !== 4'd9) $display("FAIL stale_tag: got %0d want %0d", rd_tag[3:0], 9); else pass_cnt++;
    disp(5'd3, 4'd2); cdb(1, 5'd3, 4'd9, 32'h22); #1;
    chk_cnt++; if (rd_busy[0] !== 1'b0) $display("FAIL disp_invisible_busy: got %b want %b", rd_busy[0], 1'b0); else pass_cnt++;
    tick(); idle(); #1;
    chk_cnt++; if (rd_busy[0] !== 1'b1) $display("FAIL disp_override_busy: got %b want %b", rd_busy[0], 1'b1); else pass_cnt++;
    chk_cnt++; if (rd_tag[7:4] !== 4'd2) $display("FAIL disp_override_tag: got %0d want %0d", rd_tag[7:4], 2); else pass_cnt++;
    chk_cnt++; if (rd_data[31:0] !== 32'h22) $display("FAIL disp_override_data: got %h want %h", rd_data[31:0], 32'h22); else pass_cnt++;
  endtask

  task automatic test_multi_cdb();
    idle(); rd(5'd4, 5'd4); cdb(0, 5'd4, 4'd1, 32'hA); cdb(1, 5'd4, 4'd1, 32'hB); #1;
    chk_cnt++; if (rd_data[63:32] !== 32'hB) $display("FAIL multi_bypass: got %h want %h", rd_data[63:32], 32'hB); else pass_cnt++;
    tick(); idle(); #1;
    chk_cnt++; if (rd_data[31:0] !== 32'hB) $display("FAIL multi_stored: got %h want %h", rd_data[31:0], 32'hB); else pass_cnt++;
    disp(5'd4, 4'd5); tick();
    idle(); cdb(0, 5'd4, 4'd5, 32'hC); cdb(1, 5'd4, 4'd6, 32'hD); #1;
    chk_cnt++; if (rd_data[63:32] !== 32'hD) $display("FAIL multi_low_tag_data: got %h want %h", rd_data[63:32], 32'hD); else pass_cnt++;
    chk_cnt++; if (rd_busy[1] !== 1'b0) $display("FAIL multi_low_tag_busy: got %b want %b", rd_busy[1], 1'b0); else pass_cnt++;
    tick(); idle(); #1;
    chk_cnt++; if (rd_busy[0] !== 1'b0) $display("FAIL multi_stored_busy: got %b want %b", rd_busy[0], 1'b0); else pass_cnt++;
    chk_cnt++; if (rd_data[31:0] !== 32'hD) $display("FAIL multi_stored_data2: got %h want %h", rd_data[31:0], 32'hD); else pass_cnt++;
  endtask

  task automatic test_ckpt_tracking();
    idle(); rd(5'd6, 5'd6); disp(5'd6, 4'd3); ckpt_save = 1'b1; ckpt_id = 2'd1; tick();
    idle(); disp(5'd6, 4'd5); tick();
    idle(); cdb(0, 5'd6, 4'd3, 32'h66); tick();
    idle(); #1;
    chk_cnt++; if (rd_busy[0] !== 1'b1) $display("FAIL track_live_busy: got %b want %b", rd_busy[0], 1'b1); else pass_cnt++;
    chk_cnt++; if (rd_tag[3:0] !== 4'd5) $display("FAIL track_live_tag: got %0d want %0d", rd_tag[3:0], 5); else pass_cnt++;
    ckpt_restore = 1'b1; restore_id = 2'd1; tick();
    idle(); #1;
    chk_cnt++; if (rd_busy[0] !== 1'b0) $display("FAIL track_restored_busy: got %b want %b", rd_busy[0], 1'b0); else pass_cnt++;
    chk_cnt++; if (rd_data[31:0] !== 32'h66) $display("FAIL track_data_kept: got %h want %h", rd_data[31:0], 32'h66); else pass_cnt++;
  endtask

  task automatic test_ckpt_restore();
    idle(); rd(5'd8, 5'd8); disp(5'd8, 4'd4); tick();
    idle(); ckpt_save = 1'b1; ckpt_id = 2'd2; tick();
    idle(); disp(5'd8, 4'd6); tick();
    idle(); #1;
    chk_cnt++; if (rd_tag[3:0] !== 4'd6) $display("FAIL rest_pre_tag: got %0d want %0d", rd_tag[3:0], 6); else pass_cnt++;
    ckpt_restore = 1'b1; restore_id = 2'd2; cdb(0, 5'd8, 4'd4, 32'h44); tick();
    idle(); #1;
    chk_cnt++; if (rd_busy[0] !== 1'b0) $display("FAIL rest_snap_clear_busy: got %b want %b", rd_busy[0], 1'b0); else pass_cnt++;
    chk_cnt++; if (rd_data[31:0] !== 32'h44) $display("FAIL rest_cdb_data: got %h want %h", rd_data[31:0], 32'h44); else pass_cnt++;
    rd(5'd9, 5'd10); disp(5'd9, 4'd1); ckpt_save = 1'b1; ckpt_id = 2'd0; tick();
    idle(); #1;
    chk_cnt++; if (rd_busy[0] !== 1'b1) $display("FAIL rest_r9_busy: got %b want %b", rd_busy[0], 1'b1); else pass_cnt++;
    ckpt_restore = 1'b1; restore_id = 2'd3; ckpt_save = 1'b1; ckpt_id = 2'd0; disp(5'd10, 4'd2); tick();
    idle(); #1;
    chk_cnt++; if (rd_busy !== 2'b00) $display("FAIL rest_unsaved_slot: got %b want %b", rd_busy, 2'b00); else pass_cnt++;
    ckpt_restore = 1'b1; restore_id = 2'd0; tick();
    idle(); #1;
    chk_cnt++; if (rd_busy[0] !== 1'b1) $display("FAIL rest_save_ignored_busy: got %b want %b", rd_busy[0], 1'b1); else pass_cnt++;
    chk_cnt++; if (rd_tag[3:0] !== 4'd1) $display("FAIL rest_save_ignored_tag: got %0d want %0d", rd_tag[3:0], 1); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    idle(); rd(5'd12, 5'd9); disp(5'd12, 4'd3); tick();
    idle(); #1;
    chk_cnt++; if (rd_busy !== 2'b11) $display("FAIL mid_pre_busy: got %b want %b", rd_busy, 2'b11); else pass_cnt++;
    rst = 1'b1; ckpt_save = 1'b1; ckpt_id = 2'd3; tick();
    rst = 1'b0; idle(); #1;
    chk_cnt++; if (rd_busy !== 2'b00) $display("FAIL mid_post_busy: got %b want %b", rd_busy, 2'b00); else pass_cnt++;
    ckpt_restore = 1'b1; restore_id = 2'd0; tick();
    idle(); #1;
    chk_cnt++; if (rd_busy[1] !== 1'b0) $display("FAIL mid_ckpt_cleared: got %b want %b", rd_busy[1], 1'b0); else pass_cnt++;
  endtask

  initial begin
    idle(); rd(5'd0, 5'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_cdb_wakeup();
    test_stale_tag();
    test_multi_cdb();
    test_ckpt_tracking();
    test_ckpt_restore();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
